// File: rtl/mem_stage_lsu.sv
// Memory-access stage between execute and writeback: runs one load/store at a time on the data port.
// Optional misaligned-access trap is enabled by defining MSU_MISALIGN_CHECK_EN (adds output ms_misalign).
module mem_stage_lsu #(
    parameter int PC_WD      = 64,
    parameter int RF_ADDR_WD = 5,
    parameter int RF_DATA_WD = 64,
    parameter int ES_BUS_WD  = 6 + RF_ADDR_WD + 2*RF_DATA_WD + PC_WD,
    parameter int WS_BUS_WD  = 1 + RF_ADDR_WD + RF_DATA_WD + PC_WD
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 es_to_ms_valid,
    input  logic [ES_BUS_WD-1:0]                 es_to_ms_bus,
    output logic                                 ms_allowin,
    input  logic                                 ws_allowin,
    output logic                                 ms_to_ws_valid,
    output logic [WS_BUS_WD-1:0]                 ms_to_ws_bus,
    output logic                                 data_req,
    input  logic                                 data_req_ready,
    output logic                                 data_we,
    output logic [PC_WD-1:0]                     data_addr,
    output logic [7:0]                           data_wstrb,
    output logic [RF_DATA_WD-1:0]                data_wdata,
    input  logic                                 data_rvalid,
    input  logic [RF_DATA_WD-1:0]                data_rdata,
    output logic [1+RF_DATA_WD+RF_ADDR_WD-1:0]   ms_forward_bus,
    output logic                                 ms_load_pending
`ifdef MSU_MISALIGN_CHECK_EN
    ,
    output logic                                 ms_misalign
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        DONE      = 2'd2
    } state_t;

    localparam int FLG_LSB = PC_WD + 2*RF_DATA_WD + RF_ADDR_WD;

    state_t                  state_q, state_d;
    logic                    ms_valid_q;
    logic [ES_BUS_WD-1:0]    es_bus_q;
    logic [RF_DATA_WD-1:0]   result_q, result_d;
    logic                    misalign_q, misalign_d;
    logic                    ms_ready_go;
    logic                    misalign_w;

    logic                    op_ld, op_st, op_uns, op_rf_we, mem_op;
    logic [1:0]              op_size;
    logic [RF_ADDR_WD-1:0]   op_rd;
    logic [RF_DATA_WD-1:0]   op_alu, op_st_data;
    logic [PC_WD-1:0]        op_pc;
    logic [2:0]              off;

    assign op_pc      = es_bus_q[PC_WD-1:0];
    assign op_st_data = es_bus_q[PC_WD +: RF_DATA_WD];
    assign op_alu     = es_bus_q[PC_WD+RF_DATA_WD +: RF_DATA_WD];
    assign op_rd      = es_bus_q[PC_WD+2*RF_DATA_WD +: RF_ADDR_WD];
    assign op_rf_we   = es_bus_q[FLG_LSB];
    assign op_uns     = es_bus_q[FLG_LSB+1];
    assign op_size    = es_bus_q[FLG_LSB+3:FLG_LSB+2];
    assign op_st      = es_bus_q[FLG_LSB+4];
    assign op_ld      = es_bus_q[FLG_LSB+5];
    assign mem_op     = op_ld | op_st;
    assign off        = op_alu[2:0];

    // Byte lane gi is enabled when it falls inside [off, off+bytes).
    logic [3:0] nbytes;
    logic [7:0] strb_w;
    assign nbytes = 4'd1 << op_size;
    for (genvar gi = 0; gi < 8; gi++) begin : g_strb
        assign strb_w[gi] = ({1'b0, off} <= 4'(gi)) && (4'(gi) < ({1'b0, off} + nbytes));
    end

    logic [RF_DATA_WD-1:0] rdata_shift, load_data;
    logic                  sext;
    assign rdata_shift = data_rdata >> {off, 3'b000};
    assign sext        = ~op_uns;

    always_comb begin
        load_data = rdata_shift;
        case (op_size)
            2'd0: load_data = {{(RF_DATA_WD-8){sext & rdata_shift[7]}},  rdata_shift[7:0]};
            2'd1: load_data = {{(RF_DATA_WD-16){sext & rdata_shift[15]}}, rdata_shift[15:0]};
            2'd2: load_data = {{(RF_DATA_WD-32){sext & rdata_shift[31]}}, rdata_shift[31:0]};
            default: load_data = rdata_shift;
        endcase
    end

`ifdef MSU_MISALIGN_CHECK_EN
    logic misaligned;
    always_comb begin
        case (op_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = |off[1:0];
            default: misaligned = |off;
        endcase
    end
    assign misalign_w  = ms_valid_q && mem_op && (state_q == IDLE) && misaligned;
    assign ms_misalign = misalign_w;
`else
    assign misalign_w = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        misalign_d  = misalign_q;
        ms_ready_go = 1'b0;
        data_req    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ms_valid_q) begin
                    if (!mem_op) begin
                        ms_ready_go = 1'b1;
                    end else if (misalign_w) begin
                        misalign_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        data_req = 1'b1;
                        if (data_req_ready) begin
                            state_d = op_st ? DONE : WAIT_RESP;
                        end
                    end
                end
            end
            WAIT_RESP: begin
                if (data_rvalid) begin
                    result_d = load_data;
                    state_d  = DONE;
                end
            end
            DONE: begin
                ms_ready_go = 1'b1;
                if (ws_allowin) begin
                    state_d    = IDLE;
                    misalign_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ms_valid_q <= 1'b0;
            es_bus_q   <= '0;
            result_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            misalign_q <= misalign_d;
            if (ms_allowin) begin
                ms_valid_q <= es_to_ms_valid;
            end
            if (es_to_ms_valid && ms_allowin) begin
                es_bus_q <= es_to_ms_bus;
            end
        end
    end

    // Loads report the captured response; everything else reports the ALU result.
    logic [RF_DATA_WD-1:0] result_w;
    logic                  rf_we_w;
    assign result_w = op_ld ? result_q : op_alu;
    assign rf_we_w  = ms_valid_q && op_rf_we && !misalign_q;

    assign ms_allowin      = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid  = ms_valid_q && ms_ready_go;
    assign ms_to_ws_bus    = {rf_we_w, op_rd, result_w, op_pc};

    assign data_we         = data_req && op_st;
    assign data_addr       = op_alu;
    assign data_wstrb      = data_req ? strb_w : 8'h00;
    assign data_wdata      = op_st_data << {off, 3'b000};

    assign ms_forward_bus  = {rf_we_w && (!op_ld || state_q == DONE), result_w, op_rd};
    assign ms_load_pending = ms_valid_q && op_ld && (state_q != DONE);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: event-level reference model plus literal checks of the worked examples.
module tb_mem_stage_lsu;

    logic          clk;
    logic          reset;
    logic          es_to_ms_valid;
    logic [202:0]  es_to_ms_bus;
    logic          ms_allowin;
    logic          ws_allowin;
    logic          ms_to_ws_valid;
    logic [133:0]  ms_to_ws_bus;
    logic          data_req;
    logic          data_req_ready;
    logic          data_we;
    logic [63:0]   data_addr;
    logic [7:0]    data_wstrb;
    logic [63:0]   data_wdata;
    logic          data_rvalid;
    logic [63:0]   data_rdata;
    logic [69:0]   ms_forward_bus;
    logic          ms_load_pending;

    mem_stage_lsu dut (
        .clk             (clk),
        .reset           (reset),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_allowin      (ms_allowin),
        .ws_allowin      (ws_allowin),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_req        (data_req),
        .data_req_ready  (data_req_ready),
        .data_we         (data_we),
        .data_addr       (data_addr),
        .data_wstrb      (data_wstrb),
        .data_wdata      (data_wdata),
        .data_rvalid     (data_rvalid),
        .data_rdata      (data_rdata),
        .ms_forward_bus  (ms_forward_bus),
        .ms_load_pending (ms_load_pending)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [202:0] mk(input logic ld, input logic st, input logic [1:0] sz,
                                        input logic uns, input logic rfwe, input logic [4:0] rd,
                                        input logic [63:0] alu, input logic [63:0] sd,
                                        input logic [63:0] pc);
        return {ld, st, sz, uns, rfwe, rd, alu, sd, pc};
    endfunction

    // Reference arithmetic: byte count, lane mask and extension straight from the access rules.
    function automatic logic [7:0] m_strb(input logic [1:0] sz, input logic [2:0] off);
        int nb;
        int m;
        nb = 1 << sz;
        m  = ((1 << nb) - 1) << off;
        return m[7:0];
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] sd, input logic [2:0] off);
        return sd << (8 * off);
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rdat, input logic [2:0] off,
                                           input logic [1:0] sz, input logic uns);
        int nb;
        logic [63:0] v;
        logic [63:0] mask;
        nb   = 1 << sz;
        v    = rdat >> (8 * off);
        mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        v    = v & mask;
        if (!uns && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    // Memory side: request acceptance after ready_lat waiting cycles, response resp_lat cycles later.
    logic [63:0] mem [0:7];
    int          ready_lat = 0;
    int          resp_lat  = 1;
    int          resp_cnt  = 0;
    int          req_age   = 0;
    logic [63:0] resp_data = '0;
    bit          acc_evt   = 0;
    bit          resp_evt  = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        data_req_ready = 0;
        data_rvalid    = 0;
        data_rdata     = '0;
        forever begin
            @(negedge clk);
            data_rvalid = 0;
            data_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    data_rvalid = 1;
                    data_rdata  = resp_data;
                    resp_evt    = 1;
                end
            end
            if (data_req) begin
                if (req_age >= ready_lat) begin
                    data_req_ready = 1;
                    req_age        = 0;
                    acc_evt        = 1;
                    if (!data_we) begin
                        resp_cnt  = resp_lat;
                        resp_data = mem[data_addr[5:3]];
                    end
                end else begin
                    data_req_ready = 0;
                    req_age++;
                end
            end else begin
                data_req_ready = 0;
                req_age        = 0;
            end
        end
    end

    // Reference model: the single instruction held by the stage and how far it has progressed.
    bit           m_valid = 0;
    logic [202:0] m_bus   = '0;
    bit           m_acc   = 0;
    bit           m_done  = 0;
    logic [63:0]  m_rdata = '0;
    int           acc_cyc = 0;

    int           req_cycles   = 0;
    logic [7:0]   last_wstrb   = '0;
    logic [63:0]  last_wdata   = '0;
    logic [133:0] last_ws_bus  = '0;
    int           last_ret_cyc = 0;
    int           ret_total    = 0;
    int           ret_cyc_q[$];
    logic [63:0]  ret_pc_q[$];

    initial begin
        logic        e_ld, e_st, e_uns, e_we, e_mem, e_rdy, e_allow, e_req, e_fwd;
        logic [1:0]  e_sz;
        logic [4:0]  e_rd;
        logic [63:0] e_alu, e_sd, e_pc, e_res;
        forever begin
            @(posedge clk);
            #2;
            if (!reset) begin
                m_valid  = 0;
                acc_evt  = 0;
                resp_evt = 0;
                chk("reset_ctrl", {ms_allowin, ms_to_ws_valid, data_req, data_we, data_wstrb,
                                   ms_forward_bus[69], ms_load_pending}, {1'b1, 13'h0});
                chk("reset_data", {ms_to_ws_bus, data_addr, data_wdata, ms_forward_bus}, 320'h0);
                continue;
            end
            {e_ld, e_st, e_sz, e_uns, e_we, e_rd, e_alu, e_sd, e_pc} = m_bus;
            if (acc_evt) begin
                acc_evt = 0;
                if (m_valid) begin
                    m_acc = 1;
                    if (e_st) m_done = 1;
                end
            end
            if (resp_evt) begin
                resp_evt = 0;
                if (m_valid && e_ld && m_acc) m_done = 1;
            end
            e_mem   = e_ld | e_st;
            e_rdy   = m_valid && (!e_mem || m_done);
            e_allow = !m_valid || (e_rdy && ws_allowin);
            e_req   = m_valid && e_mem && !m_acc;
            e_fwd   = m_valid && e_we && (!e_ld || m_done);
            e_res   = e_ld ? m_load(m_rdata, e_alu[2:0], e_sz, e_uns) : e_alu;

            chk("ms_to_ws_valid", ms_to_ws_valid, e_rdy);
            chk("ms_allowin", ms_allowin, e_allow);
            chk("data_req", data_req, e_req);
            chk("ms_load_pending", ms_load_pending, m_valid && e_ld && !m_done);
            if (e_fwd) chk("forward_bus", ms_forward_bus, {1'b1, e_res, e_rd});
            else       chk("forward_valid", ms_forward_bus[69], 1'b0);
            if (e_req) begin
                chk("req_addr_we", {data_addr, data_we}, {e_alu, e_st});
                if (e_st) chk("req_store", {data_wstrb, data_wdata},
                              {m_strb(e_sz, e_alu[2:0]), m_wdata(e_sd, e_alu[2:0])});
            end
            if (e_rdy) chk("ws_bus", ms_to_ws_bus, {m_valid && e_we, e_rd, e_res, e_pc});

            if (data_req) begin
                req_cycles++;
                last_wstrb = data_wstrb;
                last_wdata = data_wdata;
            end
            if (ms_to_ws_valid && ws_allowin) begin
                last_ws_bus  = ms_to_ws_bus;
                last_ret_cyc = cyc;
                ret_cyc_q.push_back(cyc);
                ret_pc_q.push_back(ms_to_ws_bus[63:0]);
                ret_total++;
            end

            if (e_rdy && ws_allowin) m_valid = 0;
            if (es_to_ms_valid && e_allow) begin
                m_valid = 1;
                m_bus   = es_to_ms_bus;
                m_acc   = 0;
                m_done  = 0;
                m_rdata = mem[es_to_ms_bus[133:131]];
                acc_cyc = cyc + 1;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one instruction and hold it until the stage takes it (bounded wait).
    task automatic issue(input logic [202:0] b);
        int t;
        t = 0;
        es_to_ms_bus   = b;
        es_to_ms_valid = 1;
        forever begin
            @(negedge clk);
            if (ms_allowin) break;
            t++;
            if (t > 200) begin
                chk("issue_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        es_to_ms_valid = 0;
    endtask

    typedef struct { logic [1:0] sz; logic [63:0] addr; logic [63:0] sd; } st_vec_t;

    initial begin
        int          saved;
        int          base;
        st_vec_t     svec[4];
        logic [63:0] exp_pc;

        reset          = 0;
        es_to_ms_valid = 0;
        es_to_ms_bus   = '0;
        ws_allowin     = 1;
        for (int i = 0; i < 8; i++) mem[i] = 64'h0101_0101_0101_0101 * (i + 1);
        wait_cyc(3);
        reset = 1;
        wait_cyc(1);

        // Non-memory op retires in its own cycle with no data request.
        req_cycles = 0;
        issue(mk(0, 0, 2'd0, 0, 1, 5'd5, 64'h1234, 64'h0, 64'h100));
        wait_cyc(2);
        chk("nonmem_bus", last_ws_bus, {1'b1, 5'd5, 64'h1234, 64'h100});
        chk("nonmem_latency", last_ret_cyc - acc_cyc, 0);
        chk("nonmem_no_req", req_cycles, 0);

        // Halfword store held for three wait cycles.
        req_cycles = 0;
        ready_lat  = 3;
        issue(mk(0, 1, 2'd1, 0, 0, 5'd0, 64'h1002, 64'hBEEF, 64'h104));
        wait_cyc(8);
        chk("store_req_cycles", req_cycles, 4);
        chk("store_wstrb", last_wstrb, 8'h0C);
        chk("store_wdata", last_wdata, 64'h0000_0000_BEEF_0000);
        chk("store_latency", last_ret_cyc - acc_cyc, 4);
        chk("store_pc", last_ws_bus[63:0], 64'h104);

        // Byte loads at offset 3, signed then unsigned.
        ready_lat = 0;
        resp_lat  = 2;
        mem[0]    = 64'h0000_0000_80FF_0000;
        issue(mk(1, 0, 2'd0, 0, 1, 5'd7, 64'h2003, 64'h0, 64'h108));
        wait_cyc(8);
        chk("ldb_signed", last_ws_bus[127:64], 64'hFFFF_FFFF_FFFF_FF80);
        chk("ldb_latency", last_ret_cyc - acc_cyc, 3);
        issue(mk(1, 0, 2'd0, 1, 1, 5'd7, 64'h2003, 64'h0, 64'h10C));
        wait_cyc(8);
        chk("ldb_unsigned", last_ws_bus[127:64], 64'h80);

        // Completed load stalled by writeback for several cycles.
        resp_lat   = 1;
        ws_allowin = 0;
        mem[1]     = 64'h1122_3344_5566_7788;
        issue(mk(1, 0, 2'd3, 0, 1, 5'd9, 64'h2008, 64'h0, 64'h110));
        wait_cyc(6);
        @(negedge clk);
        chk("stall_allowin", ms_allowin, 1'b0);
        chk("stall_fwd", ms_forward_bus, {1'b1, 64'h1122_3344_5566_7788, 5'd9});
        chk("stall_bus_a", ms_to_ws_bus, {1'b1, 5'd9, 64'h1122_3344_5566_7788, 64'h110});
        wait_cyc(3);
        chk("stall_bus_b", ms_to_ws_bus, {1'b1, 5'd9, 64'h1122_3344_5566_7788, 64'h110});
        ws_allowin = 1;
        wait_cyc(3);
        chk("stall_release_pc", last_ws_bus[63:0], 64'h110);

        // Asynchronous reset while waiting for a load response; the late response must be ignored.
        resp_lat = 6;
        issue(mk(1, 0, 2'd2, 0, 1, 5'd3, 64'h2010, 64'h0, 64'h114));
        @(posedge clk);
        #4;
        reset = 0;
        #1;
        chk("async_reset_ctrl", {data_req, ms_to_ws_valid, ms_allowin, ms_load_pending},
            {1'b0, 1'b0, 1'b1, 1'b0});
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1;
        saved = ret_total;
        wait_cyc(10);
        chk("stale_resp_no_retire", ret_total, saved);
        chk("post_reset_allowin", ms_allowin, 1'b1);

        // Back-to-back loads with single-cycle responses.
        resp_lat = 1;
        mem[3]   = 64'hF0E1_D2C3_B4A5_9687;
        mem[4]   = 64'h8000_7FFF_0123_4567;
        mem[5]   = 64'h9ABC_DEF0_1234_5678;
        ret_cyc_q.delete();
        ret_pc_q.delete();
        issue(mk(1, 0, 2'd0, 0, 1, 5'd1, 64'h201D, 64'h0, 64'h200));
        issue(mk(1, 0, 2'd1, 0, 1, 5'd2, 64'h2026, 64'h0, 64'h204));
        issue(mk(1, 0, 2'd2, 1, 1, 5'd3, 64'h202C, 64'h0, 64'h208));
        issue(mk(1, 0, 2'd3, 0, 1, 5'd4, 64'h2018, 64'h0, 64'h20C));
        wait_cyc(10);
        chk("b2b_count", ret_pc_q.size(), 4);
        if (ret_pc_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                exp_pc = 64'h200 + 64'(4 * i);
                chk($sformatf("b2b_pc%0d", i), ret_pc_q[i], exp_pc);
                if (i > 0) chk($sformatf("b2b_gap%0d", i), ret_cyc_q[i] - ret_cyc_q[i-1], 3);
            end
        end
        chk("b2b_last_result", last_ws_bus[127:64], 64'hF0E1_D2C3_B4A5_9687);

        // Stores of each size plus a non-writing ALU op.
        ready_lat = 1;
        svec[0] = '{2'd0, 64'h3007, 64'h0000_0000_0000_00A5};
        svec[1] = '{2'd1, 64'h3006, 64'h0000_0000_0000_1234};
        svec[2] = '{2'd2, 64'h3004, 64'h0000_0000_CAFE_F00D};
        svec[3] = '{2'd3, 64'h3008, 64'h0123_4567_89AB_CDEF};
        base = ret_total;
        for (int i = 0; i < 4; i++) begin
            issue(mk(0, 1, svec[i].sz, 0, 0, 5'd0, svec[i].addr, svec[i].sd, 64'h300 + 64'(4 * i)));
        end
        issue(mk(0, 0, 2'd0, 0, 0, 5'd11, 64'h5555, 64'h0, 64'h310));
        wait_cyc(8);
        chk("store_table_count", ret_total - base, 5);
        chk("last_store_wstrb", last_wstrb, 8'hFF);
        chk("nonwrite_bus", last_ws_bus, {1'b0, 5'd11, 64'h5555, 64'h310});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
